// File: rtl/sortmax_pkg.sv
// Shared constants for the sortmax datapath: micro-op strobe and condition flag bit positions.
package sortmax_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_DEPTH = 8;

   localparam int unsigned N_Y = 20;
   localparam int unsigned N_X = 5;

   localparam int unsigned Y_CLR_SWAP  = 0;
   localparam int unsigned Y_CLR_I     = 1;
   localparam int unsigned Y_CLR_J     = 2;
   localparam int unsigned Y_INC_J     = 3;
   localparam int unsigned Y_INC_I     = 4;
   localparam int unsigned Y_LD_M0     = 5;
   localparam int unsigned Y_DONE      = 6;
   localparam int unsigned Y_CLR_START = 7;
   localparam int unsigned Y_LD_A      = 8;
   localparam int unsigned Y_LD_B      = 9;
   localparam int unsigned Y_MAX_A     = 10;
   localparam int unsigned Y_MAX_B     = 11;
   localparam int unsigned Y_WR_J      = 12;
   localparam int unsigned Y_WR_J1     = 13;
   localparam int unsigned Y_SET_SWAP  = 14;
   localparam int unsigned Y_LD_MAX    = 15;
   localparam int unsigned Y_HOLD_RD   = 16;
   localparam int unsigned Y_CLR_M     = 17;
   localparam int unsigned Y_OR_SWAP   = 18;
   localparam int unsigned Y_NOP       = 19;

   localparam int unsigned X_LAST  = 0;
   localparam int unsigned X_SWAP  = 1;
   localparam int unsigned X_MODE  = 2;
   localparam int unsigned X_LEN1  = 3;
   localparam int unsigned X_START = 4;

endpackage

// File: rtl/sortmax_cmp.sv
// Unsigned magnitude compare: gt_c = (a > b), max_c = larger operand (b on a tie).
module sortmax_cmp
   import sortmax_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt_c,
   output logic [WIDTH-1:0] max_c
);

   assign gt_c  = (a > b);
   assign max_c = gt_c ? a : b;

endmodule

// File: rtl/sortmax_datapath.sv
// Sortmax execution datapath: applies FSM micro-op strobes to a small word array and returns branch flags.
// Optional SORTMAX_DP_CONFLICT_CHK_EN adds a sticky err output for conflicting strobe pairs.
module sortmax_datapath
   import sortmax_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_Y-1:0]   y,
   output logic [N_X-1:0]   x,
   input  logic             start,
   input  logic             mode_max,
   input  logic [AW:0]      len,
   input  logic             host_we,
   input  logic [AW-1:0]    host_addr,
   input  logic [WIDTH-1:0] host_wdata,
   output logic [WIDTH-1:0] host_rdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] max_out
`ifdef SORTMAX_DP_CONFLICT_CHK_EN
   ,
   output logic             err
`endif
);

   localparam int unsigned LW = AW + 1;
   localparam int unsigned XW = AW + 2;
   localparam logic [AW-1:0] IDX_MAX = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    i, j, jp1;
   logic [WIDTH-1:0] a, b, m, m_nxt, rd_nxt;
   logic [LW-1:0]    len_q;
   logic             mode_q, start_q, swap_q, swap_nxt, host_hit;
   logic             gt_ab, unused_gt_ma, unused_gt_mb;
   logic [WIDTH-1:0] max_ma, max_mb, unused_max_ab;
   logic             unused_nop;

   assign unused_nop = y[Y_NOP];
   assign jp1        = (j == IDX_MAX) ? j : j + AW'(1);
   assign host_hit   = LW'(host_addr) < LW'(DEPTH);
   assign rd_nxt     = host_hit ? mem[host_addr] : '0;

   sortmax_cmp #(.WIDTH(WIDTH)) u_cmp_ab (.a(a), .b(b), .gt_c(gt_ab),        .max_c(unused_max_ab));
   sortmax_cmp #(.WIDTH(WIDTH)) u_cmp_ma (.a(m), .b(a), .gt_c(unused_gt_ma), .max_c(max_ma));
   sortmax_cmp #(.WIDTH(WIDTH)) u_cmp_mb (.a(m), .b(b), .gt_c(unused_gt_mb), .max_c(max_mb));

   // Running max: clear beats load-from-mem[0], which beats the compare updates.
   always_comb begin
      m_nxt = m;
      if (y[Y_CLR_M])                      m_nxt = '0;
      else if (y[Y_LD_M0])                 m_nxt = mem[0];
      else if (y[Y_MAX_A] && y[Y_MAX_B])   m_nxt = gt_ab ? max_ma : max_mb;
      else if (y[Y_MAX_A])                 m_nxt = max_ma;
      else if (y[Y_MAX_B])                 m_nxt = max_mb;
   end

   always_comb begin
      swap_nxt = swap_q;
      if (y[Y_CLR_SWAP])                          swap_nxt = 1'b0;
      if ((y[Y_SET_SWAP] || y[Y_OR_SWAP]) && gt_ab) swap_nxt = 1'b1;
   end

   always_comb begin
      x          = '0;
      x[X_LAST]  = busy && ((XW'(j) + XW'(2)) >= XW'(len_q));
      x[X_SWAP]  = swap_q;
      x[X_MODE]  = mode_q;
      x[X_LEN1]  = (len_q == LW'(1));
      x[X_START] = start_q;
   end

   // Array: host writes only while idle; the swap pair lands on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else begin
         if (host_we && !busy && host_hit) mem[host_addr] <= host_wdata;
         if (y[Y_WR_J])                    mem[j]         <= b;
         if (y[Y_WR_J1])                   mem[jp1]       <= a;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i          <= '0;
         j          <= '0;
         a          <= '0;
         b          <= '0;
         m          <= '0;
         max_out    <= '0;
         host_rdata <= '0;
         len_q      <= '0;
         mode_q     <= 1'b0;
         start_q    <= 1'b0;
         swap_q     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done   <= y[Y_DONE];
         m      <= m_nxt;
         swap_q <= swap_nxt;
         if (y[Y_CLR_I])                        i <= '0;
         else if (y[Y_INC_I] && i != IDX_MAX)   i <= i + AW'(1);
         if (y[Y_CLR_J])                        j <= '0;
         else if (y[Y_INC_J] && j != IDX_MAX)   j <= j + AW'(1);
         if (y[Y_LD_A])      a          <= mem[j];
         if (y[Y_LD_B])      b          <= mem[jp1];
         if (y[Y_LD_MAX])    max_out    <= m;
         if (!y[Y_HOLD_RD])  host_rdata <= rd_nxt;
         if (y[Y_DONE])      busy       <= 1'b0;
         if (y[Y_CLR_START]) start_q    <= 1'b0;
         if (start && !busy) begin
            start_q <= 1'b1;
            busy    <= 1'b1;
            len_q   <= len;
            mode_q  <= mode_max;
         end
      end
   end

`ifdef SORTMAX_DP_CONFLICT_CHK_EN
   // Sticky flag for strobe pairs the FSM should never issue together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err <= 1'b0;
      else if ((y[Y_CLR_I] && y[Y_INC_I]) || (y[Y_CLR_J] && y[Y_INC_J]) ||
               (y[Y_LD_M0] && y[Y_CLR_M]) || (y[Y_DONE] && y[Y_CLR_START]))
         err <= 1'b1;
   end
`endif

endmodule
